decode_stage_pipe: RTL and testbench

Pipelined, parametrised decode stage for the 16-bit processor. It sits between fetch and execute and contains:
- an integrated register file with optional write-to-read bypass;
- immediate extraction and extension to the datapath width;
- load-use hazard detection with single-bubble stall insertion;
- a valid/ready-handshaked ID/EX output register with flush.

Control decoding (opcode → control bits) stays in the external control block; this block consumes its outputs.

---
 rtl/decode_stage_pipe.sv | 194 +++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
// Decode stage between fetch and execute. Holds the architectural register
// file, extends immediates to the datapath width, detects load-use hazards
// (one bubble per dependency) and drives a valid/ready ID/EX register that
// can be flushed.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   in_valid / in_ready      fetch-side handshake
//   in_instr, in_pc          instruction word and its PC+2
//   in_rs_used, in_rt_used   instruction reads rs / rt
//   in_reg_write, in_wsel    destination write enable / select
//   in_mem_read              instruction is a load
//   in_imm_sel, in_imm_sext  immediate format and sign mode
//   wb_en, wb_sel, wb_data   register file writeback
//   flush                    kill held and incoming instruction
//   out_valid / out_ready    execute-side handshake
//   out_rs_data, out_rt_data operands
//   out_imm, out_pc          extended immediate, registered PC
//   out_wsel, out_reg_write, out_mem_read  registered control
//   err                      held instruction used an illegal imm_sel
module decode_stage_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              in_rs_used,
    input  logic              in_rt_used,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_wsel,
    input  logic              in_mem_read,
    input  logic [1:0]        in_imm_sel,
    input  logic              in_imm_sext,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_wsel,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              err
);

    // Register file
    logic [DATA_W-1:0] rf_q [NREGS];

    // ID/EX register
    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [DATA_W-1:0] pc_q,        pc_d;
    logic [ADDR_W-1:0] wsel_q,      wsel_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              illegal_q,   illegal_d;
    // Source selects of the held instruction, needed to refresh its operands
    logic [ADDR_W-1:0] rs_sel_q,    rs_sel_d;
    logic [ADDR_W-1:0] rt_sel_q,    rt_sel_d;

    logic [ADDR_W-1:0] rs, rt;
    logic [DATA_W-1:0] rs_rd, rt_rd;
    logic [DATA_W-1:0] imm_ext;
    logic              imm_illegal;
    logic              stall;
    logic              in_xfer, out_xfer;
    logic              unused_instr;

    assign rs = in_instr[8 +: ADDR_W];
    assign rt = in_instr[5 +: ADDR_W];
    // Opcode bits are decoded by the external control block
    assign unused_instr = ^in_instr;

    // Load in ID/EX whose destination is a source of the incoming instruction
    assign stall = valid_q && mem_read_q && reg_write_q &&
                   ((in_rs_used && (rs == wsel_q)) || (in_rt_used && (rt == wsel_q)));

    assign in_ready = rst && !flush && !stall && (!valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = valid_q && out_ready;

    // Operand reads with optional same-cycle writeback forwarding
    always_comb begin
        rs_rd = rf_q[rs];
        rt_rd = rf_q[rt];
        if (BYPASS != 0 && wb_en) begin
            if (wb_sel == rs) rs_rd = wb_data;
            if (wb_sel == rt) rt_rd = wb_data;
        end
    end

    // Immediate extraction and extension
    always_comb begin
        imm_ext     = '0;
        imm_illegal = 1'b0;
        case (in_imm_sel)
            2'd0: imm_ext = in_imm_sext ? {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]}
                                        : {{(DATA_W-5){1'b0}}, in_instr[4:0]};
            2'd1: imm_ext = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
            2'd2: imm_ext = {{(DATA_W-11){in_instr[10]}}, in_instr[10:0]};
            default: imm_illegal = 1'b1;
        endcase
    end

    // ID/EX next state: flush > load > drain (bubble) > hold with refresh
    always_comb begin
        valid_d     = valid_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        wsel_d      = wsel_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        illegal_d   = illegal_q;
        rs_sel_d    = rs_sel_q;
        rt_sel_d    = rt_sel_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            valid_d     = 1'b1;
            rs_data_d   = rs_rd;
            rt_data_d   = rt_rd;
            imm_d       = imm_ext;
            pc_d        = in_pc;
            wsel_d      = in_wsel;
            reg_write_d = in_reg_write;
            mem_read_d  = in_mem_read;
            illegal_d   = imm_illegal;
            rs_sel_d    = rs;
            rt_sel_d    = rt;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end else if (BYPASS != 0 && valid_q && wb_en) begin
            // Held instruction must not go to execute with a stale operand
            if (wb_sel == rs_sel_q) rs_data_d = wb_data;
            if (wb_sel == rt_sel_q) rt_data_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
            valid_q     <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            wsel_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            illegal_q   <= 1'b0;
            rs_sel_q    <= '0;
            rt_sel_q    <= '0;
        end else begin
            if (wb_en) rf_q[wb_sel] <= wb_data;
            valid_q     <= valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            wsel_q      <= wsel_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            illegal_q   <= illegal_d;
            rs_sel_q    <= rs_sel_d;
            rt_sel_q    <= rt_sel_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_rs_data   = rs_data_q;
    assign out_rt_data   = rt_data_q;
    assign out_imm       = imm_q;
    assign out_pc        = pc_q;
    assign out_wsel      = wsel_q;
    assign out_reg_write = reg_write_q;
    assign out_mem_read  = mem_read_q;
    assign err           = valid_q && illegal_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe
// Directed bench for decode_stage_pipe. Two instances share all inputs:
// dut_b (BYPASS=1) and dut_n (BYPASS=0); they differ only in captured and
// held operand values. Inputs change 1 time unit after the rising edge,
// outputs are sampled at that same point.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_rs_used, in_rt_used, in_reg_write, in_mem_read, in_imm_sext;
    logic [2:0]  in_wsel;
    logic [1:0]  in_imm_sel;
    logic        wb_en;
    logic [2:0]  wb_sel;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_ready;

    logic        b_in_ready, b_out_valid, b_out_reg_write, b_out_mem_read, b_err;
    logic [15:0] b_out_rs_data, b_out_rt_data, b_out_imm, b_out_pc;
    logic [2:0]  b_out_wsel;
    logic        n_in_ready, n_out_valid, n_out_reg_write, n_out_mem_read, n_err;
    logic [15:0] n_out_rs_data, n_out_rt_data, n_out_imm, n_out_pc;
    logic [2:0]  n_out_wsel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage_pipe #(.DATA_W(16), .NREGS(8), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs_used(in_rs_used),
        .in_rt_used(in_rt_used), .in_reg_write(in_reg_write), .in_wsel(in_wsel),
        .in_mem_read(in_mem_read), .in_imm_sel(in_imm_sel), .in_imm_sext(in_imm_sext),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_rs_data(b_out_rs_data), .out_rt_data(b_out_rt_data), .out_imm(b_out_imm),
        .out_pc(b_out_pc), .out_wsel(b_out_wsel), .out_reg_write(b_out_reg_write),
        .out_mem_read(b_out_mem_read), .err(b_err)
    );

    decode_stage_pipe #(.DATA_W(16), .NREGS(8), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs_used(in_rs_used),
        .in_rt_used(in_rt_used), .in_reg_write(in_reg_write), .in_wsel(in_wsel),
        .in_mem_read(in_mem_read), .in_imm_sel(in_imm_sel), .in_imm_sext(in_imm_sext),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_rs_data(n_out_rs_data), .out_rt_data(n_out_rt_data), .out_imm(n_out_imm),
        .out_pc(n_out_pc), .out_wsel(n_out_wsel), .out_reg_write(n_out_reg_write),
        .out_mem_read(n_out_mem_read), .err(n_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_instr     = '0;
        in_pc        = '0;
        in_rs_used   = 1'b0;
        in_rt_used   = 1'b0;
        in_reg_write = 1'b0;
        in_wsel      = '0;
        in_mem_read  = 1'b0;
        in_imm_sel   = 2'd0;
        in_imm_sext  = 1'b0;
        wb_en        = 1'b0;
        wb_sel       = '0;
        wb_data      = '0;
        flush        = 1'b0;
        out_ready    = 1'b1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] pc,
                         input logic rsu, input logic rtu, input logic [1:0] isel);
        in_valid     = 1'b1;
        in_instr     = instr;
        in_pc        = pc;
        in_rs_used   = rsu;
        in_rt_used   = rtu;
        in_imm_sel   = isel;
        in_imm_sext  = 1'b0;
        in_reg_write = 1'b0;
        in_mem_read  = 1'b0;
        in_wsel      = '0;
    endtask

    task automatic wb_write(input logic [2:0] sel, input logic [15:0] data);
        in_valid = 1'b0;
        wb_en    = 1'b1;
        wb_sel   = sel;
        wb_data  = data;
        step();
        wb_en    = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", b_out_valid); end
        tests++; if (b_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", b_err); end
        tests++; if (b_in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready_low got %b exp 0", b_in_ready); end
        tests++; if (b_out_pc !== 16'h0000) begin fails++; $display("FAIL rst_out_pc got %h exp 0000", b_out_pc); end
        rst = 1'b1;
        #1;
        tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready_rel got %b exp 1", b_in_ready); end
        // read R7 and R6 after reset
        drive(16'h07C0, 16'h0010, 1'b1, 1'b1, 2'd0);
        step();
        tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL rst_read_valid got %b exp 1", b_out_valid); end
        tests++; if (b_out_rs_data !== 16'h0000) begin fails++; $display("FAIL rst_read_r7 got %h exp 0000", b_out_rs_data); end
        tests++; if (n_out_rt_data !== 16'h0000) begin fails++; $display("FAIL rst_read_r6 got %h exp 0000", n_out_rt_data); end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins   [4] = '{16'h0180, 16'h0230, 16'h0230, 16'h0501};
        logic [1:0]  sel   [4] = '{2'd1, 2'd0, 2'd0, 2'd2};
        logic        sx    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] e_imm [4] = '{16'hFF80, 16'hFFF0, 16'h0010, 16'hFD01};
        logic [15:0] e_rs  [4] = '{16'h1111, 16'h2222, 16'h2222, 16'h5555};
        logic [15:0] e_rt  [4] = '{16'h0000, 16'h1111, 16'h1111, 16'h0000};
        logic [15:0] e_pc;
        idle();
        wb_write(3'd1, 16'h1111);
        wb_write(3'd2, 16'h2222);
        wb_write(3'd5, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            e_pc = 16'h0100 + 16'(2 * i);
            drive(ins[i], e_pc, 1'b1, 1'b1, sel[i]);
            in_imm_sext  = sx[i];
            in_reg_write = 1'b1;
            in_wsel      = 3'(i);
            #1;
            tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got %b exp 1", i, b_in_ready); end
            step();
            tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid%0d got %b exp 1", i, b_out_valid); end
            tests++; if (b_out_pc !== e_pc) begin fails++; $display("FAIL b2b_pc%0d got %h exp %h", i, b_out_pc, e_pc); end
            tests++; if (b_out_imm !== e_imm[i]) begin fails++; $display("FAIL b2b_imm%0d got %h exp %h", i, b_out_imm, e_imm[i]); end
            tests++; if (b_out_rs_data !== e_rs[i]) begin fails++; $display("FAIL b2b_rs%0d got %h exp %h", i, b_out_rs_data, e_rs[i]); end
            tests++; if (b_out_rt_data !== e_rt[i]) begin fails++; $display("FAIL b2b_rt%0d got %h exp %h", i, b_out_rt_data, e_rt[i]); end
            tests++; if (b_out_wsel !== 3'(i)) begin fails++; $display("FAIL b2b_wsel%0d got %0d exp %0d", i, b_out_wsel, i); end
        end
        idle();
        step();
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", b_out_valid); end
    endtask

    task automatic test_load_use();
        idle();
        drive(16'h0000, 16'h0200, 1'b0, 1'b0, 2'd0);
        in_reg_write = 1'b1;
        in_mem_read  = 1'b1;
        in_wsel      = 3'd3;
        step();
        tests++; if (b_out_mem_read !== 1'b1) begin fails++; $display("FAIL lu_load_held got %b exp 1", b_out_mem_read); end
        drive(16'h0300, 16'h0202, 1'b1, 1'b0, 2'd0);
        #1;
        tests++; if (b_in_ready !== 1'b0) begin fails++; $display("FAIL lu_stall got %b exp 0", b_in_ready); end
        step();
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble got %b exp 0", b_out_valid); end
        tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL lu_resume got %b exp 1", b_in_ready); end
        step();
        tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL lu_dep_valid got %b exp 1", b_out_valid); end
        tests++; if (b_out_pc !== 16'h0202) begin fails++; $display("FAIL lu_dep_pc got %h exp 0202", b_out_pc); end
        idle();
        step();
        // Independent consumer (reads R4): no bubble
        drive(16'h0000, 16'h0210, 1'b0, 1'b0, 2'd0);
        in_reg_write = 1'b1;
        in_mem_read  = 1'b1;
        in_wsel      = 3'd3;
        step();
        drive(16'h0400, 16'h0212, 1'b1, 1'b0, 2'd0);
        #1;
        tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL lu_nodep_ready got %b exp 1", b_in_ready); end
        step();
        tests++; if (b_out_pc !== 16'h0212) begin fails++; $display("FAIL lu_nodep_pc got %h exp 0212", b_out_pc); end
        idle();
        step();
    endtask

    task automatic test_bypass();
        idle();
        wb_write(3'd2, 16'h0AAA);
        drive(16'h0200, 16'h0400, 1'b1, 1'b0, 2'd0);
        wb_en   = 1'b1;
        wb_sel  = 3'd2;
        wb_data = 16'h1234;
        step();
        tests++; if (b_out_rs_data !== 16'h1234) begin fails++; $display("FAIL byp_accept got %h exp 1234", b_out_rs_data); end
        tests++; if (n_out_rs_data !== 16'h0AAA) begin fails++; $display("FAIL nobyp_accept got %h exp 0AAA", n_out_rs_data); end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wb_data   = 16'h5678;
        step();
        tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL byp_hold_valid got %b exp 1", b_out_valid); end
        tests++; if (b_out_rs_data !== 16'h5678) begin fails++; $display("FAIL byp_held got %h exp 5678", b_out_rs_data); end
        tests++; if (n_out_rs_data !== 16'h0AAA) begin fails++; $display("FAIL nobyp_held got %h exp 0AAA", n_out_rs_data); end
        wb_sel  = 3'd6;
        wb_data = 16'h9999;
        step();
        tests++; if (b_out_rs_data !== 16'h5678) begin fails++; $display("FAIL byp_other_reg got %h exp 5678", b_out_rs_data); end
        idle();
        step();
    endtask

    task automatic test_flush();
        idle();
        drive(16'h0000, 16'h0300, 1'b0, 1'b0, 2'd0);
        out_ready = 1'b0;
        step();
        tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL fl_held got %b exp 1", b_out_valid); end
        drive(16'h0000, 16'h0302, 1'b0, 1'b0, 2'd0);
        flush   = 1'b1;
        wb_en   = 1'b1;
        wb_sel  = 3'd5;
        wb_data = 16'hBEEF;
        #1;
        tests++; if (b_in_ready !== 1'b0) begin fails++; $display("FAIL fl_in_ready got %b exp 0", b_in_ready); end
        step();
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL fl_cleared got %b exp 0", b_out_valid); end
        idle();
        step();
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL fl_dropped got %b exp 0", b_out_valid); end
        drive(16'h0500, 16'h0304, 1'b1, 1'b0, 2'd0);
        step();
        tests++; if (b_out_rs_data !== 16'hBEEF) begin fails++; $display("FAIL fl_wb_b got %h exp BEEF", b_out_rs_data); end
        tests++; if (n_out_rs_data !== 16'hBEEF) begin fails++; $display("FAIL fl_wb_n got %h exp BEEF", n_out_rs_data); end
        idle();
        step();
    endtask

    task automatic test_illegal_and_reset();
        idle();
        drive(16'h001F, 16'h0500, 1'b0, 1'b0, 2'd3);
        out_ready = 1'b0;
        step();
        tests++; if (b_out_imm !== 16'h0000) begin fails++; $display("FAIL ill_imm got %h exp 0000", b_out_imm); end
        tests++; if (b_err !== 1'b1) begin fails++; $display("FAIL ill_err got %b exp 1", b_err); end
        in_valid = 1'b0;
        step();
        tests++; if (b_err !== 1'b1) begin fails++; $display("FAIL ill_err_hold got %b exp 1", b_err); end
        out_ready = 1'b1;
        step();
        tests++; if (b_err !== 1'b0) begin fails++; $display("FAIL ill_err_gone got %b exp 0", b_err); end
        // Illegal load held, dependent instruction stalled, then reset
        drive(16'h001F, 16'h0600, 1'b0, 1'b0, 2'd3);
        in_reg_write = 1'b1;
        in_mem_read  = 1'b1;
        in_wsel      = 3'd3;
        out_ready    = 1'b0;
        step();
        tests++; if (b_err !== 1'b1) begin fails++; $display("FAIL rs_err_pre got %b exp 1", b_err); end
        drive(16'h0300, 16'h0602, 1'b1, 1'b0, 2'd0);
        #1;
        tests++; if (b_in_ready !== 1'b0) begin fails++; $display("FAIL rs_stall got %b exp 0", b_in_ready); end
        rst = 1'b0;
        step();
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL rs_valid got %b exp 0", b_out_valid); end
        tests++; if (b_err !== 1'b0) begin fails++; $display("FAIL rs_err got %b exp 0", b_err); end
        tests++; if (b_out_mem_read !== 1'b0) begin fails++; $display("FAIL rs_memrd got %b exp 0", b_out_mem_read); end
        rst = 1'b1;
        idle();
        step();
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL rs_discard got %b exp 0", b_out_valid); end
        drive(16'h0200, 16'h0700, 1'b1, 1'b0, 2'd0);
        step();
        tests++; if (b_out_rs_data !== 16'h0000) begin fails++; $display("FAIL rs_rf_clear got %h exp 0000", b_out_rs_data); end
        idle();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_bypass();
        test_flush();
        test_illegal_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
